// File: rtl/cdec_mem_bus_if_if.sv
// Bus bundle between the CDEC core, the memory bus interface unit and memory.
// master = the bus interface unit, slave = the core/memory environment around it.
interface cdec_mem_bus_if_if #(
  parameter int DATA_W = 8,
  parameter int ADRS_W = 8
);
  // Handshake: the core holds mmrw/core_adrs/core_wdata stable while stall is high;
  // memory completes an access by raising mem_ready while an enable is high, and the
  // unit honours it only once the minimum wait states have elapsed.
  logic [1:0]        mmrw;
  logic [ADRS_W-1:0] core_adrs;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              stall;
  logic [ADRS_W-1:0] adrs;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic              mmwr_en;
  logic              mmrd_en;
  logic              mem_ready;
  logic              bus_err;

  modport master (
    input  mmrw, core_adrs, core_wdata, data_in, mem_ready,
    output core_rdata, stall, adrs, data_out, mmwr_en, mmrd_en, bus_err
  );

  modport slave (
    output mmrw, core_adrs, core_wdata, data_in, mem_ready,
    input  core_rdata, stall, adrs, data_out, mmwr_en, mmrd_en, bus_err
  );
endinterface

// File: rtl/cdec_mem_bus_if.sv
// CDEC memory bus interface unit: mmrw command -> multi-cycle read/write with wait states.
// Optional access timeout with sticky bus_err is enabled by defining CDEC_BUS_TIMEOUT_EN.
module cdec_mem_bus_if #(
  parameter int DATA_W   = 8,
  parameter int ADRS_W   = 8,
  parameter int WAIT_CYC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic       clock,
  input  logic       reset_N,
  cdec_mem_bus_if_if.master bus,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [1:0] CMD_WR = 2'b01;
  localparam logic [1:0] CMD_RD = 2'b10;

  localparam logic [7:0] WAIT_LIM    = 8'(WAIT_CYC);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  logic [1:0]        state_q;
  logic [7:0]        wait_cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADRS_W-1:0] adrs_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic              bus_err_q;

  logic is_req;
  logic wait_met;
  logic complete;
  logic timeout_hit;

  assign is_req = (bus.mmrw == CMD_WR) || (bus.mmrw == CMD_RD);
  // Phrased as cnt+1 > lim so WAIT_CYC=0 does not degenerate into an unsigned >= 0.
  assign wait_met = ({1'b0, wait_cnt_q} + 9'd1) > {1'b0, WAIT_LIM};
  assign complete = (state_q == ST_ACCESS) && wait_met && bus.mem_ready;

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 8'd0;
      rdata_q    <= '0;
      adrs_q     <= '0;
      wdata_q    <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_req) begin
            adrs_q     <= bus.core_adrs;
            if (bus.mmrw == CMD_WR) wdata_q <= bus.core_wdata;
            wr_en_q    <= (bus.mmrw == CMD_WR);
            rd_en_q    <= (bus.mmrw == CMD_RD);
            wait_cnt_q <= 8'd0;
            state_q    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt_q != 8'hFF) wait_cnt_q <= wait_cnt_q + 8'd1;
          if (complete) begin
            if (rd_en_q) rdata_q <= bus.data_in;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            state_q <= ST_DONE;
          end else if (timeout_hit) begin
            // Aborted read returns all-ones; an aborted write is simply dropped.
            if (rd_en_q) rdata_q <= '1;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CDEC_BUS_TIMEOUT_EN
  logic [7:0] to_cnt_q;

  // Completion takes priority, so the limit only fires when the access is still pending.
  assign timeout_hit = (state_q == ST_ACCESS) && !complete &&
                       (to_cnt_q == (TIMEOUT_LIM - 8'd1));

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      to_cnt_q  <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && is_req) begin
        to_cnt_q <= 8'd0;
      end else if (state_q == ST_ACCESS && to_cnt_q != 8'hFF) begin
        to_cnt_q <= to_cnt_q + 8'd1;
      end
      if (timeout_hit) bus_err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign bus_err_q          = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_LIM;
`endif

  // Gated by reset so the core sees no stall while the unit is held in reset.
  assign bus.stall      = reset_N &&
                          (((state_q == ST_IDLE) && is_req) || (state_q == ST_ACCESS));
  assign bus.core_rdata = rdata_q;
  assign bus.adrs       = adrs_q;
  assign bus.data_out   = wdata_q;
  assign bus.mmwr_en    = wr_en_q;
  assign bus.mmrd_en    = rd_en_q;
  assign bus.bus_err    = bus_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_cdec_mem_bus_if.sv
// Directed bench for cdec_mem_bus_if: WAIT_CYC=0 instance (u_dut0) and WAIT_CYC=2 instance (u_dut1).
module tb_cdec_mem_bus_if;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cdec_mem_bus_if_if bif0 ();
  cdec_mem_bus_if_if bif1 ();
  logic [1:0] st0, st1;

  cdec_mem_bus_if #(.DATA_W(8), .ADRS_W(8), .WAIT_CYC(0), .TIMEOUT(15)) u_dut0 (
    .clock(clk), .reset_N(rst_n), .bus(bif0.master), .dbg_state(st0)
  );

  cdec_mem_bus_if #(.DATA_W(8), .ADRS_W(8), .WAIT_CYC(2), .TIMEOUT(15)) u_dut1 (
    .clock(clk), .reset_N(rst_n), .bus(bif1.master), .dbg_state(st1)
  );

  int checks = 0;
  int errors = 0;

  logic       s_stall, s_rd, s_wr, s_err;
  logic [7:0] s_rdata, s_adrs, s_dout;
  logic [1:0] s_state;

  int n_stall, n_rd, n_wr, n_cyc;

  // ---------------- driver tasks ----------------
  task automatic drive(input int which, input logic [1:0] cmd, input logic [7:0] a,
                       input logic [7:0] w, input logic [7:0] din, input logic rdy);
    if (which == 0) begin
      bif0.mmrw = cmd; bif0.core_adrs = a; bif0.core_wdata = w;
      bif0.data_in = din; bif0.mem_ready = rdy;
    end else begin
      bif1.mmrw = cmd; bif1.core_adrs = a; bif1.core_wdata = w;
      bif1.data_in = din; bif1.mem_ready = rdy;
    end
  endtask

  task automatic sample(input int which);
    if (which == 0) begin
      s_stall = bif0.stall; s_rd = bif0.mmrd_en; s_wr = bif0.mmwr_en; s_err = bif0.bus_err;
      s_rdata = bif0.core_rdata; s_adrs = bif0.adrs; s_dout = bif0.data_out; s_state = st0;
    end else begin
      s_stall = bif1.stall; s_rd = bif1.mmrd_en; s_wr = bif1.mmwr_en; s_err = bif1.bus_err;
      s_rdata = bif1.core_rdata; s_adrs = bif1.adrs; s_dout = bif1.data_out; s_state = st1;
    end
  endtask

  // Issues one command and holds it while stalled; mem_ready is low for the first
  // ready_low ACCESS cycles, and data_in carries rd_val only on the first ready cycle.
  task automatic run_txn(input int which, input logic [1:0] cmd, input logic [7:0] a,
                         input logic [7:0] w, input logic [7:0] rd_val, input int ready_low);
    n_stall = 0; n_rd = 0; n_wr = 0; n_cyc = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      drive(which, cmd, a, w, (i == ready_low + 1) ? rd_val : ~rd_val, (i > ready_low));
      #1;
      sample(which);
      if (s_stall) n_stall++;
      if (s_rd) n_rd++;
      if (s_wr) n_wr++;
      n_cyc = i;
      if (!s_stall && i > 0) break;
    end
    drive(which, 2'b00, a, w, 8'h00, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
    drive(1, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
    #12;
    sample(0);
    checks++;
    if ({s_stall, s_rd, s_wr, s_err, s_rdata, s_adrs, s_dout, s_state} !== 29'd0) begin
      errors++;
      $display("FAIL reset_state: got stall=%0b rd=%0b wr=%0b err=%0b rdata=%h adrs=%h dout=%h st=%0d, want all 0",
               s_stall, s_rd, s_wr, s_err, s_rdata, s_adrs, s_dout, s_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_no_wait;
    run_txn(0, 2'b10, 8'h3C, 8'h00, 8'hA5, 0);
    checks++;
    if (n_stall !== 2) begin errors++; $display("FAIL read0_stall: got %0d want 2", n_stall); end
    checks++;
    if (n_rd !== 1 || n_wr !== 0) begin
      errors++; $display("FAIL read0_enables: got rd=%0d wr=%0d want rd=1 wr=0", n_rd, n_wr);
    end
    checks++;
    if (s_rdata !== 8'hA5) begin errors++; $display("FAIL read0_rdata: got %h want a5", s_rdata); end
    checks++;
    if (s_adrs !== 8'h3C) begin errors++; $display("FAIL read0_adrs: got %h want 3c", s_adrs); end
  endtask

  task automatic test_write_wait;
    run_txn(1, 2'b01, 8'h10, 8'h5A, 8'h00, 0);
    checks++;
    if (n_wr !== 3 || n_rd !== 0) begin
      errors++; $display("FAIL write2_enables: got wr=%0d rd=%0d want wr=3 rd=0", n_wr, n_rd);
    end
    checks++;
    if (n_stall !== 4) begin errors++; $display("FAIL write2_stall: got %0d want 4", n_stall); end
    checks++;
    if (s_adrs !== 8'h10 || s_dout !== 8'h5A) begin
      errors++; $display("FAIL write2_bus: got adrs=%h dout=%h want 10 5a", s_adrs, s_dout);
    end
    checks++;
    if (s_rdata !== 8'h00) begin errors++; $display("FAIL write2_rdata: got %h want 00", s_rdata); end
  endtask

  task automatic test_ready_low;
    run_txn(0, 2'b10, 8'h77, 8'h00, 8'h69, 4);
    checks++;
    if (n_stall !== 6) begin errors++; $display("FAIL readylow_stall: got %0d want 6", n_stall); end
    checks++;
    if (n_rd !== 5) begin errors++; $display("FAIL readylow_rd: got %0d want 5", n_rd); end
    checks++;
    if (s_rdata !== 8'h69) begin errors++; $display("FAIL readylow_rdata: got %h want 69", s_rdata); end
  endtask

  task automatic test_write_keeps_rdata;
    run_txn(0, 2'b01, 8'h22, 8'h33, 8'hEE, 0);
    checks++;
    if (n_stall !== 2 || n_wr !== 1) begin
      errors++; $display("FAIL write0_timing: got stall=%0d wr=%0d want 2 1", n_stall, n_wr);
    end
    checks++;
    if (s_rdata !== 8'h69 || s_dout !== 8'h33 || s_adrs !== 8'h22) begin
      errors++; $display("FAIL write0_data: got rdata=%h dout=%h adrs=%h want 69 33 22", s_rdata, s_dout, s_adrs);
    end
  endtask

  task automatic test_reserved;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, 2'b11, 8'h99, 8'h88, 8'h11, 1'b1);
      #1;
      sample(0);
      checks++;
      if (s_stall !== 1'b0 || s_rd !== 1'b0 || s_wr !== 1'b0 || s_rdata !== 8'h69 || s_state !== 2'd0) begin
        errors++;
        $display("FAIL reserved_cmd[%0d]: got stall=%0b rd=%0b wr=%0b rdata=%h st=%0d want 0 0 0 69 0",
                 i, s_stall, s_rd, s_wr, s_rdata, s_state);
      end
    end
    drive(0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int first = -1;
    int second = -1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(0, 2'b10, 8'h5E, 8'h00, 8'hC3, 1'b1);
      #1;
      sample(0);
      if (s_rd) begin
        if (pulses == 0) first = i;
        else if (pulses == 1) second = i;
        pulses++;
      end
    end
    @(negedge clk);
    drive(0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
    #1;
    sample(0);
    checks++;
    if (pulses !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", pulses); end
    checks++;
    if (first !== 1 || second !== 4) begin
      errors++; $display("FAIL b2b_interval: got first=%0d second=%0d want 1 4", first, second);
    end
    checks++;
    if (s_stall !== 1'b0 || s_rdata !== 8'hC3) begin
      errors++; $display("FAIL b2b_end: got stall=%0b rdata=%h want 0 c3", s_stall, s_rdata);
    end
  endtask

`ifdef CDEC_BUS_TIMEOUT_EN
  task automatic test_timeout;
    run_txn(0, 2'b10, 8'h81, 8'h00, 8'h12, 100);
    checks++;
    if (n_stall !== 16 || n_rd !== 15) begin
      errors++; $display("FAIL timeout_len: got stall=%0d rd=%0d want 16 15", n_stall, n_rd);
    end
    checks++;
    if (s_rdata !== 8'hFF || s_err !== 1'b1) begin
      errors++; $display("FAIL timeout_abort: got rdata=%h err=%0b want ff 1", s_rdata, s_err);
    end
    run_txn(0, 2'b10, 8'h82, 8'h00, 8'h3E, 0);
    checks++;
    if (s_rdata !== 8'h3E || s_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got rdata=%h err=%0b want 3e 1", s_rdata, s_err);
    end
  endtask
`else
  task automatic test_long_wait;
    run_txn(0, 2'b10, 8'h81, 8'h00, 8'h12, 20);
    checks++;
    if (n_stall !== 22 || n_rd !== 21) begin
      errors++; $display("FAIL longwait_len: got stall=%0d rd=%0d want 22 21", n_stall, n_rd);
    end
    checks++;
    if (s_rdata !== 8'h12 || s_err !== 1'b0) begin
      errors++; $display("FAIL longwait_result: got rdata=%h err=%0b want 12 0", s_rdata, s_err);
    end
  endtask
`endif

  task automatic test_reset_mid_access;
    @(negedge clk);
    drive(0, 2'b10, 8'h44, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    sample(0);
    checks++;
    if (s_rd !== 1'b1 || s_stall !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: got rd=%0b stall=%0b want 1 1", s_rd, s_stall);
    end
    rst_n = 1'b0;
    #1;
    sample(0);
    checks++;
    if ({s_stall, s_rd, s_wr, s_err, s_rdata, s_adrs, s_state} !== 21'd0) begin
      errors++;
      $display("FAIL midreset_async: got stall=%0b rd=%0b wr=%0b err=%0b rdata=%h adrs=%h st=%0d want all 0",
               s_stall, s_rd, s_wr, s_err, s_rdata, s_adrs, s_state);
    end
    drive(0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    sample(0);
    checks++;
    if (s_stall !== 1'b0 || s_state !== 2'd0 || s_rdata !== 8'h00) begin
      errors++; $display("FAIL midreset_after: got stall=%0b st=%0d rdata=%h want 0 0 00", s_stall, s_state, s_rdata);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read_no_wait();
    test_write_wait();
    test_ready_low();
    test_write_keeps_rdata();
    test_reserved();
    test_back_to_back();
`ifdef CDEC_BUS_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
